// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
// Shared definitions for the UART command controller: frame FSM state
// encoding, command codes, and default header / timeout values.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4
  } state_e;

  localparam logic [7:0]  CMD_WR          = 8'h01;
  localparam logic [7:0]  CMD_RD          = 8'h02;
  localparam logic [7:0]  HEADER_DEFAULT  = 8'h55;
  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

  function automatic logic is_valid_cmd(input logic [7:0] cmd);
    return (cmd == CMD_WR) || (cmd == CMD_RD);
  endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// uart_cmd_timer
// Inter-byte timeout counter. Counts cycles of silence while enabled and
// flags expiry on the cycle that completes p_TIMEOUT silent cycles.
// Ports:
//   i_local_clk  clock
//   i_rst_n      async active-low reset
//   clear_i      clear the count (byte received or frame idle); wins over enable
//   enable_i     count while high
//   expired_o    high on the p_TIMEOUT-th consecutive silent enabled cycle
module uart_cmd_timer #(
  parameter logic [15:0] p_TIMEOUT = 16'd50000
) (
  input  logic i_local_clk,
  input  logic i_rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 16'd0;
    end else if (enable_i && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_local_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds silent cycles already elapsed, so this cycle is the last one.
  assign expired_o = enable_i && !clear_i && (cnt_q == p_TIMEOUT - 16'd1);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
// Assembles 5-byte UART command frames (HEADER, CMD, ADDR, DATA, CHK with
// CHK = CMD ^ ADDR ^ DATA) and issues register read/write strobes.
// Ports:
//   i_local_clk, i_rst_n   clock, async active-low reset
//   i_rx_valid, i_rx_data  received byte pulse and value
//   o_wr_en, o_rd_en       one-cycle register write/read strobes
//   o_addr, o_wdata        address/data of the last accepted frame
//   o_frame_err            one-cycle pulse on a rejected frame
//   o_err_cnt              saturating count of rejected frames
//   o_busy                 frame assembly in progress
//
// state  | meaning
// S_IDLE | waiting for header byte; other bytes dropped silently
// S_CMD  | header seen, expecting command byte
// S_ADDR | expecting address byte
// S_DATA | expecting data byte
// S_CHK  | expecting checksum byte; accept or reject frame
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [15:0] p_TIMEOUT = TIMEOUT_DEFAULT,
  parameter logic [7:0]  p_HEADER  = HEADER_DEFAULT
) (
  input  logic       i_local_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic       o_wr_en,
  output logic       o_rd_en,
  output logic [7:0] o_addr,
  output logic [7:0] o_wdata,
  output logic       o_frame_err,
  output logic [7:0] o_err_cnt,
  output logic       o_busy
);

  state_e     state_q;
  logic [7:0] cmd_q;
  logic [7:0] addr_sh_q;
  logic [7:0] data_sh_q;
  logic [7:0] xor_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       wr_en_q;
  logic       rd_en_q;
  logic       frame_err_q;
  logic [7:0] err_cnt_q;
  logic [7:0] err_cnt_d;

  logic       tmr_expired;
  logic       tmr_clear;
  logic       tmr_enable;
  logic       reject_d;
  logic       accept_d;

  assign tmr_enable = (state_q != S_IDLE);
  assign tmr_clear  = i_rx_valid || (state_q == S_IDLE);

  uart_cmd_timer #(
    .p_TIMEOUT (p_TIMEOUT)
  ) u_timer (
    .i_local_clk (i_local_clk),
    .i_rst_n     (i_rst_n),
    .clear_i     (tmr_clear),
    .enable_i    (tmr_enable),
    .expired_o   (tmr_expired)
  );

  // Frame verdict for this cycle; a received byte always takes priority
  // over a coincident timeout.
  always_comb begin
    reject_d = 1'b0;
    accept_d = 1'b0;
    if (i_rx_valid) begin
      case (state_q)
        S_CMD: reject_d = !is_valid_cmd(i_rx_data);
        S_CHK: begin
          accept_d = (i_rx_data == xor_q);
          reject_d = (i_rx_data != xor_q);
        end
        default: ;
      endcase
    end else if (tmr_expired) begin
      reject_d = 1'b1;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (reject_d && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_local_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= 8'd0;
      addr_sh_q   <= 8'd0;
      data_sh_q   <= 8'd0;
      xor_q       <= 8'd0;
      addr_q      <= 8'd0;
      wdata_q     <= 8'd0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      frame_err_q <= reject_d;
      err_cnt_q   <= err_cnt_d;
      if (i_rx_valid) begin
        case (state_q)
          S_IDLE: begin
            if (i_rx_data == p_HEADER) begin
              state_q <= S_CMD;
            end
          end
          S_CMD: begin
            if (reject_d) begin
              state_q <= S_IDLE;
            end else begin
              cmd_q   <= i_rx_data;
              xor_q   <= i_rx_data;
              state_q <= S_ADDR;
            end
          end
          S_ADDR: begin
            addr_sh_q <= i_rx_data;
            xor_q     <= xor_q ^ i_rx_data;
            state_q   <= S_DATA;
          end
          S_DATA: begin
            data_sh_q <= i_rx_data;
            xor_q     <= xor_q ^ i_rx_data;
            state_q   <= S_CHK;
          end
          S_CHK: begin
            state_q <= S_IDLE;
            if (accept_d) begin
              addr_q  <= addr_sh_q;
              wdata_q <= data_sh_q;
              wr_en_q <= (cmd_q == CMD_WR);
              rd_en_q <= (cmd_q == CMD_RD);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (tmr_expired) begin
        state_q <= S_IDLE;
      end
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_rd_en     = rd_en_q;
  assign o_addr      = addr_q;
  assign o_wdata     = wdata_q;
  assign o_frame_err = frame_err_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

  localparam logic [15:0] TB_TIMEOUT = 16'd64;
  localparam logic [7:0]  TB_HEADER  = 8'h55;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       frame_err;
  logic [7:0] err_cnt;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // reference model state: bytes of the frame collected so far
  logic [7:0] mq[$];
  logic [7:0] exp_addr  = 8'd0;
  logic [7:0] exp_wdata = 8'd0;
  int         exp_err   = 0;

  uart_cmd_ctrl #(
    .p_TIMEOUT (TB_TIMEOUT),
    .p_HEADER  (TB_HEADER)
  ) dut (
    .i_local_clk (clk),
    .i_rst_n     (rst_n),
    .i_rx_valid  (rx_valid),
    .i_rx_data   (rx_data),
    .o_wr_en     (wr_en),
    .o_rd_en     (rd_en),
    .o_addr      (addr),
    .o_wdata     (wdata),
    .o_frame_err (frame_err),
    .o_err_cnt   (err_cnt),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_err();
    if (exp_err < 255) exp_err++;
  endtask

  // ev: 0 none, 1 write, 2 read, 3 rejected
  task automatic model_byte(input logic [7:0] b, output int ev);
    logic [7:0] x;
    ev = 0;
    if (mq.size() == 0) begin
      if (b == TB_HEADER) mq.push_back(b);
    end else begin
      mq.push_back(b);
      if (mq.size() == 2 && b != 8'h01 && b != 8'h02) begin
        ev = 3;
        mq.delete();
        model_err();
      end else if (mq.size() == 5) begin
        x = mq[1] ^ mq[2] ^ mq[3];
        if (x == mq[4]) begin
          ev        = (mq[1] == 8'h01) ? 1 : 2;
          exp_addr  = mq[2];
          exp_wdata = mq[3];
        end else begin
          ev = 3;
          model_err();
        end
        mq.delete();
      end
    end
  endtask

  task automatic check_outs(input string tag, input int ev);
    check_val({tag, " wr_en"},     wr_en,     ev == 1);
    check_val({tag, " rd_en"},     rd_en,     ev == 2);
    check_val({tag, " frame_err"}, frame_err, ev == 3);
    check_val({tag, " addr"},      addr,      exp_addr);
    check_val({tag, " wdata"},     wdata,     exp_wdata);
    check_val({tag, " err_cnt"},   err_cnt,   exp_err);
    check_val({tag, " busy"},      busy,      mq.size() != 0);
  endtask

  // called at a negedge; returns at a negedge
  task automatic send_byte(input string tag, input logic [7:0] b, input int gap);
    int ev;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    model_byte(b, ev);
    check_outs(tag, ev);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check_outs({tag, " gap"}, 0);
    end
  endtask

  task automatic send_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    send_byte(tag, b0, 0);
    send_byte(tag, b1, 0);
    send_byte(tag, b2, 0);
    send_byte(tag, b3, 0);
    send_byte(tag, b4, 1);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_addr  = 8'd0;
    exp_wdata = 8'd0;
    exp_err   = 0;
  endtask

  initial begin
    int          k;
    int          kind;
    logic [7:0]  c, a, d, s;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outs("reset", 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("post_reset", 0);

    // reset mid-frame drops the partial frame silently
    send_byte("rst_mid", 8'h55, 0);
    send_byte("rst_mid", 8'h01, 0);
    send_byte("rst_mid", 8'h10, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("rst_mid_async", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("rst_mid_rel", 0);
    send_frame("after_rst", 8'h55, 8'h01, 8'h10, 8'hA5, 8'hB4);

    send_frame("wr_ok",   8'h55, 8'h01, 8'h10, 8'hA5, 8'hB4);
    send_frame("rd_ok",   8'h55, 8'h02, 8'h20, 8'h00, 8'h22);
    send_frame("bad_chk", 8'h55, 8'h01, 8'h10, 8'hA5, 8'hB5);
    send_byte("bad_cmd", 8'h55, 0);
    send_byte("bad_cmd", 8'h07, 0);
    send_frame("cmd_recover", 8'h55, 8'h01, 8'h33, 8'h44, 8'h76);
    send_frame("hdr_as_data", 8'h55, 8'h01, 8'h55, 8'h55, 8'h01);

    // timeout: error pulse exactly TB_TIMEOUT silent cycles after last byte
    send_byte("tmo", 8'h55, 0);
    send_byte("tmo", 8'h01, 0);
    k = -1;
    for (int i = 1; i <= int'(TB_TIMEOUT) + 8; i++) begin
      @(negedge clk);
      if (frame_err) begin
        k = i;
        break;
      end
    end
    check_val("tmo_latency", k, int'(TB_TIMEOUT));
    mq.delete();
    model_err();
    check_outs("tmo_after", 3);
    @(negedge clk);
    check_outs("tmo_idle", 0);

    // randomized frames
    for (int f = 0; f < 200; f++) begin
      kind = $urandom_range(0, 5);
      c = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
      a = 8'($urandom);
      d = 8'($urandom);
      if (kind == 5) begin
        if ($urandom_range(0, 1) == 0) a = TB_HEADER; else d = TB_HEADER;
      end
      s = c ^ a ^ d;
      if (kind == 2) s = s ^ (8'd1 << $urandom_range(0, 7));
      if (kind == 3) begin
        c = 8'($urandom);
        if (c == 8'h01 || c == 8'h02) c = 8'h07;
      end
      if (kind == 4) begin
        for (int j = 0; j < 3; j++) begin
          a = 8'($urandom);
          if (a == TB_HEADER) a = 8'h00;
          send_byte("rnd_junk", a, $urandom_range(0, 3));
        end
      end else begin
        send_byte("rnd", TB_HEADER, $urandom_range(0, 3));
        send_byte("rnd", c, $urandom_range(0, 3));
        if (kind != 3) begin
          send_byte("rnd", a, $urandom_range(0, 3));
          send_byte("rnd", d, $urandom_range(0, 3));
          send_byte("rnd", s, $urandom_range(0, 3));
        end
      end
    end

    // saturation of the error counter
    for (int f = 0; f < 300; f++) begin
      send_byte("sat", 8'h55, 0);
      send_byte("sat", 8'h07, 0);
    end
    check_val("err_cnt_sat", err_cnt, 8'hFF);
    send_frame("sat_chk", 8'h55, 8'h02, 8'h01, 8'h02, 8'h00);
    check_val("err_cnt_hold", err_cnt, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter p_TIMEOUT, default 16'd50000, inter-byte timeout in i_local_clk cycles.
REQ-002 The block SHALL have parameter p_HEADER, default 8'h55, frame start byte.
REQ-003 i_local_clk  input  1  system clock; all logic rises on posedge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_rx_valid  input  1  one-cycle pulse: received UART byte available.
REQ-006 i_rx_data  input  8  received byte, valid when i_rx_valid=1.
REQ-007 o_wr_en  output  1  one-cycle register-write strobe.
REQ-008 o_rd_en  output  1  one-cycle register-read strobe.
REQ-009 o_addr  output  8  register address; held until next accepted frame.
REQ-010 o_wdata  output  8  write data; held until next accepted frame.
REQ-011 o_frame_err  output  1  one-cycle pulse on any rejected frame.
REQ-012 o_err_cnt  output  8  count of rejected frames.
REQ-013 o_busy  output  1  high while a frame is being assembled (state != S_IDLE).

Function
REQ-014 Frame SHALL be 5 bytes: HEADER, CMD, ADDR, DATA, CHK; CHK = CMD ^ ADDR ^ DATA (header excluded).
REQ-015 CMD 8'h01 SHALL mean write; CMD 8'h02 SHALL mean read (DATA byte received but ignored except in CHK).
REQ-016 FSM states SHALL be S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK; each transition occurs only on a cycle with i_rx_valid=1, except timeout.
REQ-017 S_IDLE: byte == p_HEADER -> S_CMD; any other byte ignored silently, no error.
REQ-018 S_CMD: byte 01/02 -> latch cmd, S_ADDR; any other value -> S_IDLE with o_frame_err.
REQ-019 S_ADDR -> S_DATA, S_DATA -> S_CHK, latching bytes into shadow registers; running XOR accumulated.
REQ-020 S_CHK: match -> S_IDLE, o_addr/o_wdata update and o_wr_en or o_rd_en pulses; mismatch -> S_IDLE, o_frame_err pulses, o_addr/o_wdata unchanged.
REQ-021 Strobe latency SHALL be exactly 1 cycle after the CHK byte's i_rx_valid cycle; o_addr/o_wdata valid in the same cycle as the strobe.
REQ-022 o_wr_en and o_rd_en SHALL never be high simultaneously; o_frame_err never coincides with either.
REQ-023 Timeout counter SHALL clear on every i_rx_valid and in S_IDLE, otherwise increment; reaching p_TIMEOUT in a non-idle state -> S_IDLE with o_frame_err.
REQ-024 Timeout and i_rx_valid in the same cycle: byte SHALL win, no timeout.
REQ-025 A p_HEADER byte received mid-frame SHALL be treated as data, not as resync.
REQ-026 o_err_cnt SHALL increment by 1 per o_frame_err and saturate at 8'hFF.
REQ-027 Output strobes SHALL be registered (no combinational path from i_rx_* to outputs).

Reset
REQ-028 On i_rst_n=0 all outputs SHALL go to 0, FSM to S_IDLE, shadow registers, XOR and timer to 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame without o_frame_err or counter change.

Structure
REQ-030 Package uart_cmd_pkg SHALL hold state encodings, CMD_WR/CMD_RD codes and default header value.
REQ-031 Timeout counter SHALL be a sub-module uart_cmd_timer (inputs clear, enable; output expired).

Verification
REQ-032 Bytes 55 01 10 A5 B4 -> o_wr_en pulse 1 cycle after B4, o_addr=10, o_wdata=A5, o_err_cnt=0.
REQ-033 Bytes 55 02 20 00 22 -> o_rd_en pulse, o_addr=20, o_wr_en stays 0.
REQ-034 Bytes 55 01 10 A5 B5 -> o_frame_err pulse, no strobe, o_addr unchanged, o_err_cnt=1.
REQ-035 Bytes 55 07 -> o_frame_err after second byte, FSM S_IDLE; subsequent valid frame accepted.
REQ-036 Bytes 55 01 then silence p_TIMEOUT cycles -> o_frame_err, o_busy falls; 300 bad frames -> o_err_cnt=FF.
REQ-037 Reset pulse after 55 01 10 -> o_busy=0, o_err_cnt unchanged at 0, next frame 55 01 10 A5 B4 accepted.
